// File: rtl/mult_div_unit.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : mult_div_unit                                                    |
// | Purpose  : Iterative multiply / divide unit. Multiply is shift-add on       |
// |            magnitudes into a 2*WIDTH accumulator; divide is restoring, one  |
// |            quotient bit per cycle. Fixed latency for every operation:       |
// |            accept -> WIDTH RUN cycles -> FIX -> DONE.                       |
// | Ports    : clock, reset (async, active-high)                                |
// |            start, op[1:0] (00 mult, 01 multu, 10 div, 11 divu), a, b        |
// |            hi (product upper / remainder), lo (product lower / quotient)    |
// |            busy, done (1-cycle pulse), div_zero (1-cycle pulse with done)   |
// | Config   : MULT_DIV_SIGNED_EN - when defined, op 00/10 are signed           |
// |            two's-complement; otherwise op[0] is ignored and all unsigned.   |
// | Revision : 1.0  initial release                                             |
// +-----------------------------------------------------------------------------+
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t               state;
  logic [CNT_W-1:0]     count;
  logic                 is_div;
  logic                 neg_res;     // result must be negated in FIX
  logic                 neg_rem;     // remainder takes the dividend sign
  logic                 b_zero;
  logic [WIDTH-1:0]     a_raw;       // original dividend, reported on divide-by-zero
  logic [WIDTH-1:0]     mcand_dvsr;  // multiplicand magnitude or divisor magnitude
  logic [WIDTH-1:0]     quo;         // dividend bits shift out the top, quotient bits in
  logic [WIDTH-1:0]     rem;
  logic [2*WIDTH-1:0]   acc;         // upper half: partial sum, lower half: multiplier

  // Signedness of the operation being presented at the inputs
  logic op_signed;
`ifdef MULT_DIV_SIGNED_EN
  assign op_signed = ~op[0];
`else
  assign op_signed = 1'b0;
  logic unused_op0;
  assign unused_op0 = op[0];
`endif

  // Operand magnitudes captured at acceptance
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] mag_a, mag_b;
  assign a_neg = op_signed & a[WIDTH-1];
  assign b_neg = op_signed & b[WIDTH-1];
  assign mag_a = a_neg ? -a : a;
  assign mag_b = b_neg ? -b : b;

  // Multiply step: conditionally add multiplicand into upper half, then shift right
  logic [WIDTH:0] mul_sum;
  assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand_dvsr} : '0);

  // Restoring divide step: the extra top bit is the guard that flags a negative trial
  logic [WIDTH:0] div_shift;
  logic [WIDTH:0] div_trial;
  logic           div_fits;
  assign div_shift = {rem, quo[WIDTH-1]};
  assign div_trial = div_shift - {1'b0, mcand_dvsr};
  assign div_fits  = ~div_trial[WIDTH];

  // Sign correction applied in FIX
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;
  assign prod_fix = neg_res ? -acc : acc;
  assign quo_fix  = neg_res ? -quo : quo;
  assign rem_fix  = neg_rem ? -rem : rem;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      count      <= '0;
      hi         <= '0;
      lo         <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      div_zero   <= 1'b0;
      is_div     <= 1'b0;
      neg_res    <= 1'b0;
      neg_rem    <= 1'b0;
      b_zero     <= 1'b0;
      a_raw      <= '0;
      mcand_dvsr <= '0;
      quo        <= '0;
      rem        <= '0;
      acc        <= '0;
    end else begin
      done     <= 1'b0;
      div_zero <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            is_div     <= op[1];
            neg_res    <= a_neg ^ b_neg;
            neg_rem    <= a_neg;
            b_zero     <= (b == '0);
            a_raw      <= a;
            mcand_dvsr <= op[1] ? mag_b : mag_a;
            acc        <= {{WIDTH{1'b0}}, mag_b};
            quo        <= mag_a;
            rem        <= '0;
            count      <= CNT_W'(WIDTH - 1);
            busy       <= 1'b1;
            state      <= RUN;
          end
        end
        RUN: begin
          if (is_div) begin
            rem <= div_fits ? div_trial[WIDTH-1:0] : div_shift[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], div_fits};
          end else begin
            acc <= {mul_sum, acc[WIDTH-1:1]};
          end
          if (count == '0) begin
            state <= FIX;
          end else begin
            count <= count - 1'b1;
          end
        end
        FIX: begin
          // Results land in hi/lo only here, so they become visible together with done
          if (!is_div) begin
            hi <= prod_fix[2*WIDTH-1:WIDTH];
            lo <= prod_fix[WIDTH-1:0];
          end else if (b_zero) begin
            hi       <= a_raw;
            lo       <= '1;
            div_zero <= 1'b1;
          end else begin
            hi <= rem_fix;
            lo <= quo_fix;
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= DONE;
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mult_div_unit.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : tb_mult_div_unit                                                 |
// | Purpose  : Self-checking bench for mult_div_unit (WIDTH=32). Directed corner |
// |            cases plus random operations compared against an arithmetic      |
// |            reference; also checks latency, busy/done timing, ignored starts |
// |            and asynchronous reset abort.                                    |
// | Config   : honours MULT_DIV_SIGNED_EN the same way as the design.           |
// | Revision : 1.0  initial release                                             |
// +-----------------------------------------------------------------------------+
module tb_mult_div_unit;

  localparam int W = 32;

  logic         clock = 1'b0;
  logic         reset;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic         busy;
  logic         done;
  logic         div_zero;

  int tests = 0;
  int fails = 0;

  logic [W-1:0] last_hi = '0;
  logic [W-1:0] last_lo = '0;

  mult_div_unit #(.WIDTH(W)) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .hi       (hi),
    .lo       (lo),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero)
  );

  always #5 clock = ~clock;

  task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: plain language arithmetic on the architectural values
  function automatic void model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                output logic [W-1:0] h, output logic [W-1:0] l, output logic dz);
    logic [63:0] p;
    longint      sx, sy, q, r;
    logic        sgn;
`ifdef MULT_DIV_SIGNED_EN
    sgn = !o[0];
`else
    sgn = 1'b0;
`endif
    dz = 1'b0;
    if (!o[1]) begin
      if (sgn) p = longint'($signed(x)) * longint'($signed(y));
      else     p = {32'd0, x} * {32'd0, y};
      h = p[63:32];
      l = p[31:0];
    end else if (y == '0) begin
      h  = x;
      l  = '1;
      dz = 1'b1;
    end else if (sgn) begin
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      q  = sx / sy;
      r  = sx % sy;
      h  = r[31:0];
      l  = q[31:0];
    end else begin
      h = x % y;
      l = x / y;
    end
  endfunction

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 6))
      0:       return '0;
      1:       return 32'd1;
      2:       return '1;
      3:       return 32'h8000_0000;
      4:       return W'($urandom_range(0, 15));
      default: return W'($urandom);
    endcase
  endfunction

  // Presents one operation (inputs change away from the clock edge), follows it
  // to completion and checks every cycle. Extra start pulses are injected during
  // RUN, FIX and DONE and must be ignored.
  task automatic run_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W-1:0] eh, el;
    logic         edz;
    int           inj;
    model(o, x, y, eh, el, edz);
    inj   = $urandom_range(W - 2, 1);
    op    = o;
    a     = x;
    b     = y;
    start = 1'b1;
    @(posedge clock); #1;
    check_value("busy_after_accept", busy, 1);
    start = 1'b0;
    a     = W'($urandom);
    b     = W'($urandom);
    op    = 2'($urandom);
    for (int k = 1; k <= W + 2; k++) begin
      @(posedge clock); #1;
      if (k <= W) begin
        check_value("busy_running", busy, 1);
        check_value("no_early_done", done, 0);
        if (k == W / 2) begin
          check_value("hi_hold", hi, last_hi);
          check_value("lo_hold", lo, last_lo);
        end
      end else if (k == W + 1) begin
        check_value("done_latency", done, 1);
        check_value("busy_in_done", busy, 0);
        check_value("div_zero", div_zero, edz);
        check_value("hi", hi, eh);
        check_value("lo", lo, el);
      end else begin
        check_value("done_one_pulse", done, 0);
        check_value("idle_busy", busy, 0);
        check_value("hi_after", hi, eh);
      end
      start = (k == inj) || (k == W) || (k == W + 1);
    end
    start = 1'b0;
    @(posedge clock); #1;
    check_value("no_queued_start", busy, 0);
    last_hi = eh;
    last_lo = el;
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    op    = 2'b00;
    a     = '0;
    b     = '0;
    #12;
    check_value("rst_hi", hi, 0);
    check_value("rst_lo", lo, 0);
    check_value("rst_busy", busy, 0);
    check_value("rst_done", done, 0);
    check_value("rst_div_zero", div_zero, 0);
    @(negedge clock);
    reset = 1'b0;

    // Directed corner cases (first one also covers acceptance on the first edge)
    run_op(2'b00, 32'd7, 32'hFFFF_FFFD);
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2);
    run_op(2'b11, 32'd100, 32'd7);
    run_op(2'b11, 32'h64, 32'd0);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(2'b10, 32'h8000_0005, 32'd0);
    run_op(2'b00, 32'h8000_0000, 32'h8000_0000);
    run_op(2'b10, 32'd7, 32'hFFFF_FFFE);

    for (int i = 0; i < 40; i++) begin
      run_op(2'($urandom), pick(), pick());
    end

    // Reset in the middle of an operation: immediate clear, no done afterwards
    op    = 2'b11;
    a     = 32'd100;
    b     = 32'd7;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (9) @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    check_value("abort_busy", busy, 0);
    check_value("abort_done", done, 0);
    check_value("abort_hi", hi, 0);
    check_value("abort_lo", lo, 0);
    check_value("abort_div_zero", div_zero, 0);
    last_hi = '0;
    last_lo = '0;
    @(negedge clock);
    reset = 1'b0;
    // Start on the first edge after release; the bench sees hi/lo hold 0 and a
    // single done at the normal latency
    run_op(2'b01, 32'h1234_5678, 32'h9ABC_DEF0);
    run_op(2'b00, 32'hFFFF_FFFF, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 Parameter: WIDTH, default 32, operand/result width; legal 8..64, even.
REQ-002 Port: clock  input  1  rising-edge clock.
REQ-003 Port: reset  input  1  asynchronous, active-high reset.
REQ-004 Port: start  input  1  request; sampled only in IDLE.
REQ-005 Port: op  input  2  00 mult, 01 multu, 10 div, 11 divu.
REQ-006 Port: a  input  WIDTH  multiplicand / dividend.
REQ-007 Port: b  input  WIDTH  multiplier / divisor.
REQ-008 Port: hi  output  WIDTH  product upper half / remainder.
REQ-009 Port: lo  output  WIDTH  product lower half / quotient.
REQ-010 Port: busy  output  1  operation in progress.
REQ-011 Port: done  output  1  one-cycle completion pulse.
REQ-012 Port: div_zero  output  1  one-cycle pulse with done when a div/divu had b==0.

Function
REQ-013 FSM states SHALL be IDLE, RUN, FIX, DONE.
REQ-014 IDLE: start=1 at edge N latches a, b, op; goes to RUN; busy=1 from cycle after edge N.
REQ-015 RUN SHALL take exactly WIDTH cycles, one iteration per cycle, counter WIDTH-1 down to 0, then FIX.
REQ-016 Multiply: shift-add on magnitudes, 2*WIDTH-bit accumulator.
REQ-017 Divide: restoring, one quotient bit per cycle; WIDTH-bit remainder plus one guard bit.
REQ-018 FIX (1 cycle): signed mult negates the 2*WIDTH product if operand signs differ; signed div negates quotient if signs differ, remainder takes dividend sign.
REQ-019 DONE (1 cycle): hi/lo updated, done=1, busy=0, next state IDLE.
REQ-020 Fixed latency: done high in cycle N+WIDTH+2 for every op, including divide-by-zero.
REQ-021 hi/lo SHALL hold last completed result until next DONE; intermediate values never visible.
REQ-022 start while busy or in DONE SHALL be ignored, no queuing.
REQ-023 Divide by zero: hi=a (original dividend), lo=all ones, div_zero=1 with done; no other flag.
REQ-024 Signed div most-negative / -1: lo=most-negative value, hi=0; no overflow flag.
REQ-025 a/b changes after start acceptance SHALL NOT affect the running operation.

Reset
REQ-026 reset=1 SHALL immediately force IDLE, hi=0, lo=0, busy=0, done=0, div_zero=0, counter=0.
REQ-027 Reset mid-operation aborts it; no done pulse; hi/lo are 0 afterward.
REQ-028 First start SHALL be accepted on the first rising edge after reset deasserts.

Configuration
REQ-029 Macro MULT_DIV_SIGNED_EN defined: op 00/10 signed two's-complement per REQ-018.
REQ-030 Macro undefined: op[0] ignored, all ops unsigned, FIX is a 1-cycle pass-through; latency per REQ-020 unchanged.

Verification (WIDTH=32, start at edge 0)
REQ-031 Signed mult 7 x 0xFFFFFFFD (macro defined) -> done cycle 34, hi=FFFFFFFF, lo=FFFFFFEB; macro undefined -> hi=00000006, lo=FFFFFFEB.
REQ-032 multu FFFFFFFF x FFFFFFFF -> hi=FFFFFFFE, lo=00000001, div_zero=0.
REQ-033 Signed div 0xFFFFFFF9 / 2 -> lo=FFFFFFFD, hi=FFFFFFFF; divu 100/7 -> lo=0000000E, hi=00000002.
REQ-034 divu 0x64 / 0 -> cycle 34 done=1, div_zero=1, hi=00000064, lo=FFFFFFFF.
REQ-035 start pulses at cycles 5 and 33 during busy -> ignored, exactly one done at cycle 34; reset at cycle 10 -> busy=0, hi=lo=0, no done.
